serial_subtractor: RTL and testbench

- Bit-serial subtractor that computes diff = a - b, LSB first, one bit per clock.
- Uses a registered borrow flip-flop between bits.
- Serial counterpart to the combinational adders: trades area for WIDTH cycles of latency.
- Start/busy/done handshake, so a controller or datapath sequencer drives it directly.

---
 rtl/serial_arith_pkg.sv | 21 ++
 rtl/f_subtractor.sv | 15 +
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic cells: FSM state encoding and
// counter sizing helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2; returns at least 1 so a counter always has one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/f_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module f_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
import serial_arith_pkg::*;

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow_ff;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic [1:0]       msb_q;
`endif

  f_subtractor u_bit (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow_ff),
    .d    (d),
    .bout (bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      borrow_ff <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      msb_q     <= '0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr      <= a;
            b_sr      <= b;
            borrow_ff <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ST_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            msb_q     <= {a[WIDTH-1], b[WIDTH-1]};
`endif
          end
        end
        ST_SHIFT: begin
          res_sr    <= {d, res_sr[WIDTH-1:1]};
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          borrow_ff <= bout;
          cnt       <= cnt + 1'b1;
          // Final bit: publish the result straight from the slice so diff
          // only changes on this edge and never during shifting.
          if (cnt == CW'(WIDTH - 1)) begin
            diff   <= {d, res_sr[WIDTH-1:1]};
            borrow <= bout;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= (msb_q[1] != msb_q[0]) && (d != msb_q[1]);
`endif
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=4).
`timescale 1ns/1ps
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8, diff8;
  logic [3:0] a4, b4, diff4;
  logic       busy8, done8, borrow8;
  logic       busy4, done4, borrow4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf4;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (borrow8)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .diff   (diff4),
    .borrow (borrow4)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    start8 = 1'b1; a8 = av; b8 = bv;
    @(negedge clk);
    start8 = 1'b0; a8 = ~av; b8 = ~bv;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_op4(input logic [3:0] av, input logic [3:0] bv, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    start4 = 1'b1; a4 = av; b4 = bv;
    @(negedge clk);
    start4 = 1'b0; a4 = ~av; b4 = ~bv;
    for (int i = 0; i < 12; i++) begin
      if (done4) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b, want all 0",
               busy8, done8, diff8, borrow8);
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_basic;
    int busy_n, done_at;
    busy_n = 0; done_at = -1;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h23;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin start8 = 1'b0; a8 = 8'h00; b8 = 8'hFF; end
      if (busy8) busy_n++;
      if (done8) begin done_at = k; break; end
    end
    checks++;
    if (done_at != 9) begin
      errors++;
      $display("FAIL basic_latency: done at cycle %0d, want 9", done_at);
    end
    checks++;
    if (busy_n != 8) begin
      errors++;
      $display("FAIL basic_busy: busy for %0d cycles, want 8", busy_n);
    end
    checks++;
    if (diff8 !== 8'h37 || borrow8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got diff=%h borrow=%b, want 37 0", diff8, borrow8);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_ovf: got %b, want 0", ovf8);
    end
`endif
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", done8);
    end
  endtask

  task automatic test_borrow;
    bit ok;
    do_op8(8'h00, 8'h01, ok);
    checks++;
    if (!ok || diff8 !== 8'hFF || borrow8 !== 1'b1) begin
      errors++;
      $display("FAIL borrow_00_01: got ok=%b diff=%h borrow=%b, want 1 FF 1", ok, diff8, borrow8);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_00_01: got %b, want 0", ovf8);
    end
`endif
    do_op8(8'h80, 8'h01, ok);
    checks++;
    if (!ok || diff8 !== 8'h7F || borrow8 !== 1'b0) begin
      errors++;
      $display("FAIL borrow_80_01: got ok=%b diff=%h borrow=%b, want 1 7F 0", ok, diff8, borrow8);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf8 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_80_01: got %b, want 1", ovf8);
    end
`endif
  endtask

  task automatic test_ignore_start;
    int busy_n, done_at, late_busy, diff_moved;
    busy_n = 0; done_at = -1; late_busy = 0; diff_moved = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h05;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin start8 = 1'b0; a8 = 8'hFF; b8 = 8'h00; end
      if (k == 3) start8 = 1'b1;
      if (k == 4) start8 = 1'b0;
      if (busy8 && k <= 8) busy_n++;
      if (busy8 && diff8 !== 8'h7F) diff_moved++;
      if (done8) begin done_at = k; start8 = 1'b1; break; end
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) begin
      if (busy8) late_busy++;
      @(negedge clk);
    end
    checks++;
    if (done_at != 9 || busy_n != 8) begin
      errors++;
      $display("FAIL ignore_timing: done at %0d busy %0d, want 9 8", done_at, busy_n);
    end
    checks++;
    if (diff_moved != 0) begin
      errors++;
      $display("FAIL ignore_diff_hold: diff changed in %0d shift cycles, want 0", diff_moved);
    end
    checks++;
    if (diff8 !== 8'h0B || borrow8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: got diff=%h borrow=%b, want 0B 0", diff8, borrow8);
    end
    checks++;
    if (late_busy != 0) begin
      errors++;
      $display("FAIL ignore_no_queue: busy in %0d cycles after done, want 0", late_busy);
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h44; b8 = 8'h11;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b diff=%h borrow=%b, want all 0",
               busy8, done8, diff8, borrow8);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) begin
        errors++;
        $display("FAIL async_reset_no_done: got done=1 after abort, want 0");
      end
    end
    do_op8(8'h09, 8'h03, ok);
    checks++;
    if (!ok || diff8 !== 8'h06 || borrow8 !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_op: got ok=%b diff=%h borrow=%b, want 1 06 0", ok, diff8, borrow8);
    end
  endtask

  task automatic test_back_to_back;
    int n_done, bad_pos, bad_res;
    n_done = 0; bad_pos = 0; bad_res = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      if (done8) begin
        n_done++;
        if (k % 10 != 9) bad_pos++;
        if (diff8 !== 8'h00 || borrow8 !== 1'b0) bad_res++;
      end
    end
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (n_done != 3 || bad_pos != 0) begin
      errors++;
      $display("FAIL b2b_spacing: %0d done pulses, %0d off-grid, want 3 and 0", n_done, bad_pos);
    end
    checks++;
    if (bad_res != 0) begin
      errors++;
      $display("FAIL b2b_result: %0d wrong results, want 0 (diff=%h borrow=%b)", bad_res, diff8, borrow8);
    end
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: busy=%b after start released, want 0", busy8);
    end
  endtask

  task automatic test_sweep4;
    bit ok;
    logic [3:0] exp_d;
    logic       exp_b;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        exp_d = 4'(ai - bi);
        exp_b = (ai < bi);
        do_op4(4'(ai), 4'(bi), ok);
        checks++;
        if (!ok || diff4 !== exp_d || borrow4 !== exp_b) begin
          errors++;
          $display("FAIL sweep4 a=%0d b=%0d: got ok=%b diff=%h borrow=%b, want %h %b",
                   ai, bi, ok, diff4, borrow4, exp_d, exp_b);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf4 !== ((ai[3] != bi[3]) && (exp_d[3] != ai[3]))) begin
          errors++;
          $display("FAIL sweep4_ovf a=%0d b=%0d: got %b", ai, bi, ovf4);
        end
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    test_reset;
    test_basic;
    test_borrow;
    test_ignore_start;
    test_async_reset;
    test_back_to_back;
    test_sweep4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
